// File: rtl/lever_ctrl.sv
// Lever sprite controller: clears the sprite RAM after reset, forwards processor pixel writes,
// and runs the pull -> timed down pose state machine. Optional macro LEVER_AUTO_EN enables ctrl[1].
module lever_ctrl #(
  parameter int ADDR        = 10,
  parameter int HOLD_FRAMES = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  input  logic            pull,
  input  logic            cfg_auto,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [ADDR-1:0] wr_addr,
  input  logic            wr_data,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic            pixel_in,
  output logic [1:0]      ctrl,
  output logic            lever_down,
  output logic            lever_evt,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  localparam logic [ADDR-1:0] CLR_LAST  = '1;
  localparam logic [9:0]      HOLD_LOAD = 10'(HOLD_FRAMES);

  state_t          state, state_nx;
  logic [ADDR-1:0] clr_cnt, clr_cnt_nx;
  logic [9:0]      hold_cnt, hold_cnt_nx;
  logic [10:0]     x_d1;
  logic            pull_s1, pull_s2, pull_prev;
  logic            we_nx, pixel_in_nx, evt_nx, wr_ready_nx;
  logic [ADDR-1:0] addr_w_nx;
  logic            frame_tick, pull_rise;

  assign frame_tick = (x_d1 == 11'd0) && (x == 11'd1) && (y == 11'd0);
  assign pull_rise  = pull_s2 & ~pull_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      clr_cnt   <= '0;
      hold_cnt  <= '0;
      x_d1      <= '0;
      pull_s1   <= 1'b0;
      pull_s2   <= 1'b0;
      pull_prev <= 1'b0;
      we        <= 1'b0;
      addr_w    <= '0;
      pixel_in  <= 1'b0;
      wr_ready  <= 1'b0;
      lever_evt <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_cnt   <= clr_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      x_d1      <= x;
      pull_s1   <= pull;
      pull_s2   <= pull_s1;
      pull_prev <= pull_s2;
      we        <= we_nx;
      addr_w    <= addr_w_nx;
      pixel_in  <= pixel_in_nx;
      wr_ready  <= wr_ready_nx;
      lever_evt <= evt_nx;
    end
  end

  // Handshake: a write transfers on any edge where wr_valid && wr_ready are both high; the
  // requester holds wr_addr/wr_data stable while wr_valid is high and not yet accepted.
  always_comb begin
    state_nx    = state;
    clr_cnt_nx  = clr_cnt;
    hold_cnt_nx = hold_cnt;
    we_nx       = 1'b0;
    addr_w_nx   = addr_w;
    pixel_in_nx = pixel_in;
    evt_nx      = 1'b0;
    wr_ready_nx = (state != S_INIT);
    case (state)
      S_INIT: begin
        we_nx       = 1'b1;
        addr_w_nx   = clr_cnt;
        pixel_in_nx = 1'b0;
        clr_cnt_nx  = clr_cnt + 1'b1;
        if (clr_cnt == CLR_LAST) state_nx = S_UP;
      end
      S_UP: begin
        if (pull_rise) begin
          state_nx    = S_DOWN;
          hold_cnt_nx = HOLD_LOAD;
        end
      end
      S_DOWN: begin
        // Further pull rises are deliberately dropped here: no reload, no queuing.
        if (frame_tick) begin
          hold_cnt_nx = hold_cnt - 1'b1;
          if (hold_cnt == 10'd1) begin
            state_nx = S_UP;
            evt_nx   = 1'b1;
          end
        end
      end
      default: state_nx = S_INIT;
    endcase
    if (state != S_INIT && wr_valid && wr_ready) begin
      we_nx       = 1'b1;
      addr_w_nx   = wr_addr;
      pixel_in_nx = wr_data;
    end
  end

  assign lever_down = (state == S_DOWN);
  assign ctrl[0]    = (state == S_DOWN);
  assign state_dbg  = state;

`ifdef LEVER_AUTO_EN
  assign ctrl[1] = (state == S_UP) & cfg_auto;
`else
  logic unused_cfg_auto;
  assign unused_cfg_auto = cfg_auto;
  assign ctrl[1]         = 1'b0;
`endif

endmodule

// File: tb/tb_lever_ctrl.sv
// Directed bench for lever_ctrl: clear sequence, write forwarding, pull/hold timing, reset abort.
module tb_lever_ctrl;

  localparam int ADDR = 10;
  localparam int W    = ADDR + 1;
`ifdef LEVER_AUTO_EN
  localparam logic [1:0] UP_CTRL = 2'b10;
`else
  localparam logic [1:0] UP_CTRL = 2'b00;
`endif

  logic            clk, reset, pull, cfg_auto, wr_valid, wr_ready, wr_data;
  logic [10:0]     x, y;
  logic [ADDR-1:0] wr_addr, addr_w;
  logic            we, pixel_in, lever_down, lever_evt;
  logic [1:0]      ctrl, state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int evt_cnt  = 0;
  int evt_base;
  logic [W-1:0] exp_q[$];

  lever_ctrl #(.ADDR(ADDR), .HOLD_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .pull(pull), .cfg_auto(cfg_auto),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .we(we), .addr_w(addr_w), .pixel_in(pixel_in), .ctrl(ctrl),
    .lever_down(lever_down), .lever_evt(lever_evt), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (lever_evt === 1'b1) evt_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic frame();
    x = 11'd0; y = 11'd0;
    tick();
    x = 11'd1;
    tick();
    x = 11'd5; y = 11'd5;
  endtask

  task automatic do_write(input logic [ADDR-1:0] a, input logic d);
    logic [W-1:0] e;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    exp_q.push_back({a, d});
    tick();
    e = exp_q.pop_front();
    chk("wr_we", we, 1);
    chk("wr_addr", addr_w, e[W-1:1]);
    chk("wr_data", pixel_in, e[0]);
  endtask

  initial begin
    reset = 1'b1; pull = 1'b0; cfg_auto = 1'b1; wr_valid = 1'b0;
    wr_addr = '0; wr_data = 1'b0; x = 11'd5; y = 11'd5;
    tick(); tick();
    chk("rst_we", we, 0);
    chk("rst_addr_w", addr_w, 0);
    chk("rst_pixel_in", pixel_in, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_lever_down", lever_down, 0);
    chk("rst_lever_evt", lever_evt, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;

    // clear sequence: edges 1..1024; writes and pulls during INIT must be ignored
    for (int k = 0; k < 1024; k++) begin
      tick();
      chk("clr_we", we, 1);
      chk("clr_addr_w", addr_w, k);
      chk("clr_pixel_in", pixel_in, 0);
      chk("clr_wr_ready", wr_ready, 0);
      chk("clr_ctrl", ctrl, 0);
      if (k == 10) begin wr_valid = 1'b1; wr_addr = '1; wr_data = 1'b1; end
      if (k == 40) wr_valid = 1'b0;
      if (k == 100) pull = 1'b1;
      if (k == 200) pull = 1'b0;
    end
    tick();
    chk("init_done_we", we, 0);
    chk("init_done_wr_ready", wr_ready, 1);
    chk("init_done_ctrl", ctrl, UP_CTRL);
    chk("init_done_down", lever_down, 0);
    chk("init_pull_ignored_evt", evt_cnt, 0);

    // back-to-back writes
    do_write(10'd5, 1'b1);
    do_write(10'd6, 1'b0);
    do_write(10'd7, 1'b1);
    wr_valid = 1'b0;
    tick();
    chk("idle_we", we, 0);
    chk("idle_addr_hold", addr_w, 7);
    chk("idle_data_hold", pixel_in, 1);

    // held pull: one down cycle of 3 frames
    evt_base = evt_cnt;
    pull = 1'b1;
    tick();
    chk("pull_n_down", lever_down, 0);
    tick();
    chk("pull_n1_down", lever_down, 0);
    tick();
    chk("pull_n2_down", lever_down, 1);
    chk("pull_n2_ctrl", ctrl, 2'b01);
    chk("down_wr_ready", wr_ready, 1);
    do_write(10'h3ff, 1'b1);
    wr_valid = 1'b0;
    frame();
    chk("f1_down", lever_down, 1);
    frame();
    chk("f2_down", lever_down, 1);
    chk("f2_evt", lever_evt, 0);
    frame();
    chk("f3_down", lever_down, 0);
    chk("f3_evt", lever_evt, 1);
    chk("f3_ctrl", ctrl, UP_CTRL);
    tick();
    chk("evt_one_cycle", lever_evt, 0);
    frame(); frame(); frame(); frame();
    chk("held_no_recycle", lever_down, 0);
    chk("held_evt_count", evt_cnt - evt_base, 1);

    // pull toggling in DOWN; tick coincident with the rise edge is not counted
    pull = 1'b0;
    repeat (4) tick();
    evt_base = evt_cnt;
    pull = 1'b1;
    tick();
    x = 11'd0; y = 11'd0;
    tick();
    x = 11'd1;
    tick();
    x = 11'd5; y = 11'd5;
    chk("rise2_down", lever_down, 1);
    pull = 1'b0;
    repeat (3) tick();
    pull = 1'b1;
    repeat (3) tick();
    frame();
    frame();
    chk("tog_f2_down", lever_down, 1);
    chk("tog_f2_evt", lever_evt, 0);
    frame();
    chk("tog_f3_down", lever_down, 0);
    chk("tog_f3_evt", lever_evt, 1);
    frame(); frame();
    chk("tog_evt_count", evt_cnt - evt_base, 1);
    chk("tog_stay_up", lever_down, 0);

    // reset during DOWN with a write pending
    pull = 1'b0;
    repeat (3) tick();
    pull = 1'b1;
    repeat (3) tick();
    chk("pre_rst_down", lever_down, 1);
    wr_valid = 1'b1; wr_addr = 10'd9; wr_data = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", ctrl, 0);
    chk("mid_rst_down", lever_down, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_addr_w", addr_w, 0);
    chk("mid_rst_state", state_dbg, 0);
    wr_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("reclr_we0", we, 1);
    chk("reclr_addr0", addr_w, 0);
    tick();
    chk("reclr_addr1", addr_w, 1);
    chk("reclr_ctrl", ctrl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
